// File: rtl/const_inst_gen_pkg.sv
// Shared constants, state encoding and LA32R encoding helpers for the
// constant-to-instruction generator.
package const_inst_gen_pkg;

  localparam logic [6:0]  OPC_LU12I = 7'b0001010;
  localparam logic [9:0]  OPC_ORI   = 10'b0000001110;
  localparam logic [9:0]  OPC_ADDI  = 10'b0000001010;
  localparam logic [31:0] INST_NOP  = 32'h0340_0000;
  localparam logic [4:0]  REG_ZERO  = 5'd0;

  typedef enum logic [1:0] {
    CIG_IDLE  = 2'd0,
    CIG_BEAT1 = 2'd1,
    CIG_BEAT2 = 2'd2
  } cig_state_t;

  function automatic logic [31:0] enc_lu12i(input logic [19:0] si20, input logic [4:0] rd);
    return {OPC_LU12I, si20, rd};
  endfunction

  function automatic logic [31:0] enc_ori(input logic [11:0] ui12, input logic [4:0] rj,
                                          input logic [4:0] rd);
    return {OPC_ORI, ui12, rj, rd};
  endfunction

  function automatic logic [31:0] enc_addi(input logic [11:0] si12, input logic [4:0] rj,
                                           input logic [4:0] rd);
    return {OPC_ADDI, si12, rj, rd};
  endfunction

endpackage

// File: rtl/const_inst_gen_if.sv
// Request and instruction-stream channels of the constant generator.
interface const_inst_gen_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_value;
  logic [4:0]  req_rd;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic        inst_last;
  logic        busy;

  modport master (
    output req_valid, req_value, req_rd, inst_ready,
    input  req_ready, inst_valid, inst, inst_last, busy
  );

  modport slave (
    input  req_valid, req_value, req_rd, inst_ready,
    output req_ready, inst_valid, inst, inst_last, busy
  );
endinterface

// File: rtl/const_inst_gen_imm_split.sv
// Combinational classifier: picks the shortest LU12I.W / ORI / ADDI.W
// sequence that rebuilds a 32-bit constant in rd.
module const_inst_gen_imm_split
  import const_inst_gen_pkg::*;
#(
  parameter bit OPT_SINGLE = 1'b1
) (
  input  logic [31:0] i_value,
  input  logic [4:0]  i_rd,
  output logic [31:0] o_first,
  output logic [31:0] o_second,
  output logic        o_single
);

  logic w_hi_zero;
  logic w_hi_ones;
  logic w_upper_zero;
  logic w_lower_zero;

  assign w_hi_zero    = (i_value[31:11] == 21'd0);
  assign w_hi_ones    = (&i_value[31:11]);
  assign w_upper_zero = (i_value[31:12] == 20'd0);
  assign w_lower_zero = (i_value[11:0] == 12'd0);

  // Default is the LU12I.W + ORI pair; shortcuts override in priority order.
  always_comb begin
    o_first  = enc_lu12i(i_value[31:12], i_rd);
    o_second = enc_ori(i_value[11:0], i_rd, i_rd);
    o_single = 1'b0;
    if (i_rd == REG_ZERO) begin
      o_first  = INST_NOP;
      o_single = 1'b1;
    end else if (OPT_SINGLE && (w_hi_zero || w_hi_ones)) begin
      o_first  = enc_addi(i_value[11:0], REG_ZERO, i_rd);
      o_single = 1'b1;
    end else if (OPT_SINGLE && w_upper_zero) begin
      o_first  = enc_ori(i_value[11:0], REG_ZERO, i_rd);
      o_single = 1'b1;
    end else if (OPT_SINGLE && w_lower_zero) begin
      o_single = 1'b1;
    end else begin
      o_single = 1'b0;
    end
  end

endmodule

// File: rtl/const_inst_gen.sv
// Streams the 1-2 instruction words that materialise a constant in a GPR,
// over a valid/ready handshake toward the fetch stage.
module const_inst_gen
  import const_inst_gen_pkg::*;
#(
  parameter bit OPT_SINGLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  const_inst_gen_if.slave  bus
);

  cig_state_t  r_state;
  cig_state_t  w_next_state;
  logic [31:0] r_inst;
  logic [31:0] r_second;
  logic        r_inst_valid;
  logic        r_inst_last;

  logic [31:0] w_first;
  logic [31:0] w_second;
  logic        w_single;
  logic        w_hs;
  logic        w_load_first;
  logic        w_load_second;
  logic        w_finish;

  const_inst_gen_imm_split #(.OPT_SINGLE(OPT_SINGLE)) u_split (
    .i_value  (bus.req_value),
    .i_rd     (bus.req_rd),
    .o_first  (w_first),
    .o_second (w_second),
    .o_single (w_single)
  );

  assign w_hs = r_inst_valid && bus.inst_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CIG_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and word-load decisions.
  always_comb begin
    w_next_state  = r_state;
    w_load_first  = 1'b0;
    w_load_second = 1'b0;
    w_finish      = 1'b0;
    case (r_state)
      CIG_IDLE: begin
        if (bus.req_valid) begin
          w_next_state = CIG_BEAT1;
          w_load_first = 1'b1;
        end else begin
          w_next_state = CIG_IDLE;
        end
      end
      CIG_BEAT1: begin
        if (w_hs && r_inst_last) begin
          w_next_state = CIG_IDLE;
          w_finish     = 1'b1;
        end else if (w_hs) begin
          w_next_state  = CIG_BEAT2;
          w_load_second = 1'b1;
        end else begin
          w_next_state = CIG_BEAT1;
        end
      end
      CIG_BEAT2: begin
        if (w_hs) begin
          w_next_state = CIG_IDLE;
          w_finish     = 1'b1;
        end else begin
          w_next_state = CIG_BEAT2;
        end
      end
      default: begin
        w_next_state = CIG_IDLE;
        w_finish     = 1'b1;
      end
    endcase
  end

  // Output word register; the ORI word replaces the first word on the same
  // edge as the first handshake so the stream has no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst       <= 32'd0;
      r_second     <= 32'd0;
      r_inst_valid <= 1'b0;
      r_inst_last  <= 1'b0;
    end else if (w_load_first) begin
      r_inst       <= w_first;
      r_second     <= w_second;
      r_inst_valid <= 1'b1;
      r_inst_last  <= w_single;
    end else if (w_load_second) begin
      r_inst       <= r_second;
      r_inst_last  <= 1'b1;
    end else if (w_finish) begin
      r_inst_valid <= 1'b0;
      r_inst_last  <= 1'b0;
    end
  end

  assign bus.req_ready  = (r_state == CIG_IDLE);
  assign bus.busy       = (r_state != CIG_IDLE);
  assign bus.inst_valid = r_inst_valid;
  assign bus.inst       = r_inst;
  assign bus.inst_last  = r_inst_last;

endmodule
